// File: rtl/huffman_enc_gen.sv
// Parametrised Huffman encoder: histograms a frame of symbols 1..N_SYM, then builds the code tree by
// repeated two-smallest merges. Optional macro HUFF_ZERO_SKIP_EN keeps zero-count symbols out of the tree.
module huffman_enc_gen #(
   parameter int N_SYM  = 6,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8,
   parameter int CODE_W = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      gray_valid,
   input  logic [DATA_W-1:0]         gray_data,
   output logic                      cnt_valid,
   output logic [N_SYM*CNT_W-1:0]    cnt,
   output logic                      code_valid,
   output logic [N_SYM*CODE_W-1:0]   hc,
   output logic [N_SYM*CODE_W-1:0]   mask
);
   localparam int WW = CNT_W + $clog2(N_SYM);
   localparam int IW = $clog2(N_SYM);

   if (CODE_W < N_SYM - 1) begin : g_code_w_chk
      $error("huffman_enc_gen: CODE_W must be >= N_SYM-1");
   end
   if (N_SYM < 2 || N_SYM > 16) begin : g_n_sym_chk
      $error("huffman_enc_gen: N_SYM must be in 2..16");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT, S_CNTDONE, S_SCAN, S_MERGE, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [IW-1:0]     round_q, round_d;
   logic [CNT_W-1:0]  cnt_q [N_SYM];
   logic [CNT_W-1:0]  cnt_d [N_SYM];
   logic [CODE_W-1:0] hc_q [N_SYM];
   logic [CODE_W-1:0] hc_d [N_SYM];
   logic [CODE_W-1:0] mask_q [N_SYM];
   logic [CODE_W-1:0] mask_d [N_SYM];
   logic [WW-1:0]     wt_q [N_SYM];
   logic [WW-1:0]     wt_d [N_SYM];
   logic [IW-1:0]     own_q [N_SYM];
   logic [IW-1:0]     own_d [N_SYM];
   logic [N_SYM-1:0]  act_q, act_d;
   logic [IW-1:0]     s1_q, s1_d, s2_q, s2_d;
   logic [WW-1:0]     w1_q, w1_d, w2_q, w2_d;
   logic              v1_q, v1_d, v2_q, v2_d;

   logic              sym_hit;
   logic [IW-1:0]     sym_idx;
   logic [31:0]       data_ext;
   logic              cur_v1, cur_v2;
   logic [WW-1:0]     cur_w;
   logic [IW-1:0]     lo_id, hi_id;
   logic              single_nz;

   assign data_ext = 32'(gray_data);

   always_comb begin
      sym_hit = 1'b0;
      sym_idx = '0;
      for (int k = 1; k <= N_SYM; k++) begin
         if (data_ext == 32'(k)) begin
            sym_hit = 1'b1;
            sym_idx = IW'(k - 1);
         end
      end
   end

   // The running min pair is discarded at the first scan step of every round.
   assign cur_v1 = v1_q & (idx_q != '0);
   assign cur_v2 = v2_q & (idx_q != '0);
   assign cur_w  = wt_q[idx_q];
   assign lo_id  = (s1_q < s2_q) ? s1_q : s2_q;
   assign hi_id  = (s1_q < s2_q) ? s2_q : s1_q;

`ifdef HUFF_ZERO_SKIP_EN
   logic [N_SYM-1:0] nz_vec;
   for (genvar gi = 0; gi < N_SYM; gi++) begin : g_nz
      assign nz_vec[gi] = |cnt_q[gi];
   end
   assign single_nz = ($countones(nz_vec) == 1);
`else
   assign single_nz = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      round_d = round_q;
      cnt_d   = cnt_q;
      hc_d    = hc_q;
      mask_d  = mask_q;
      wt_d    = wt_q;
      own_d   = own_q;
      act_d   = act_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      v1_d    = v1_q;
      v2_d    = v2_q;
      case (state_q)
         S_IDLE: begin
            if (gray_valid) begin
               for (int i = 0; i < N_SYM; i++) cnt_d[i] = '0;
               if (sym_hit) cnt_d[sym_idx] = CNT_W'(1);
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            if (gray_valid) begin
               if (sym_hit && (cnt_q[sym_idx] != '1)) cnt_d[sym_idx] = cnt_q[sym_idx] + CNT_W'(1);
            end else begin
               state_d = S_CNTDONE;
            end
         end
         S_CNTDONE: begin
            for (int i = 0; i < N_SYM; i++) begin
               hc_d[i]  = '0;
               mask_d[i] = '0;
               wt_d[i]  = WW'(cnt_q[i]);
               own_d[i] = IW'(i);
`ifdef HUFF_ZERO_SKIP_EN
               act_d[i] = (cnt_q[i] != '0);
               // A lone nonzero symbol never merges, so it gets a 1-bit code up front.
               if (single_nz && (cnt_q[i] != '0)) mask_d[i] = CODE_W'(1);
`else
               act_d[i] = 1'b1;
`endif
            end
            idx_d   = '0;
            round_d = '0;
            state_d = S_SCAN;
         end
         S_SCAN: begin
            v1_d = cur_v1;
            v2_d = cur_v2;
            if (act_q[idx_q]) begin
               // "<=" while scanning upwards makes the higher id win a weight tie.
               if (!cur_v1 || (cur_w <= w1_q)) begin
                  s2_d = s1_q;
                  w2_d = w1_q;
                  v2_d = cur_v1;
                  s1_d = idx_q;
                  w1_d = cur_w;
                  v1_d = 1'b1;
               end else if (!cur_v2 || (cur_w <= w2_q)) begin
                  s2_d = idx_q;
                  w2_d = cur_w;
                  v2_d = 1'b1;
               end
            end
            if (idx_q == IW'(N_SYM - 1)) begin
               idx_d   = '0;
               state_d = S_MERGE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         S_MERGE: begin
            if (v2_q) begin
               if (own_q[idx_q] == s1_q) begin
                  hc_d[idx_q]   = hc_q[idx_q] | (mask_q[idx_q] + CODE_W'(1));
                  mask_d[idx_q] = {mask_q[idx_q][CODE_W-2:0], 1'b1};
                  own_d[idx_q]  = lo_id;
               end else if (own_q[idx_q] == s2_q) begin
                  mask_d[idx_q] = {mask_q[idx_q][CODE_W-2:0], 1'b1};
                  own_d[idx_q]  = lo_id;
               end
            end
            if (idx_q == IW'(N_SYM - 1)) begin
               if (v2_q) begin
                  wt_d[lo_id]  = w1_q + w2_q;
                  act_d[hi_id] = 1'b0;
               end
               idx_d = '0;
               if (round_q == IW'(N_SYM - 2)) begin
                  state_d = S_DONE;
               end else begin
                  round_d = round_q + IW'(1);
                  state_d = S_SCAN;
               end
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         round_q <= '0;
         act_q   <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         w1_q    <= '0;
         w2_q    <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         for (int i = 0; i < N_SYM; i++) begin
            cnt_q[i]  <= '0;
            hc_q[i]   <= '0;
            mask_q[i] <= '0;
            wt_q[i]   <= '0;
            own_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         round_q <= round_d;
         act_q   <= act_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         cnt_q   <= cnt_d;
         hc_q    <= hc_d;
         mask_q  <= mask_d;
         wt_q    <= wt_d;
         own_q   <= own_d;
      end
   end

   assign cnt_valid  = (state_q == S_CNTDONE);
   assign code_valid = (state_q == S_DONE);

   for (genvar gi = 0; gi < N_SYM; gi++) begin : g_pack
      assign cnt[gi*CNT_W +: CNT_W]    = cnt_q[gi];
      assign hc[gi*CODE_W +: CODE_W]   = hc_q[gi];
      assign mask[gi*CODE_W +: CODE_W] = mask_q[gi];
   end

endmodule

// File: tb/tb_huffman_enc_gen.sv
// Bench for huffman_enc_gen: directed and random frames checked against a set-merging Huffman model.
// Define HUFF_ZERO_SKIP_EN for both files to exercise the zero-count skip build.
module tb_huffman_enc_gen;
   localparam int NS = 6, DW = 8, CW = 8, HW = 8;
   localparam int LAT = (NS - 1) * 2 * NS + 1;

   logic clk = 1'b0, reset = 1'b1, gray_valid = 1'b0;
   logic [DW-1:0] gray_data = '0;
   logic cnt_valid, code_valid;
   logic [NS*CW-1:0] cnt;
   logic [NS*HW-1:0] hc, mask;

   int errors = 0, checks = 0;
   int exp_cnt[NS], exp_hc[NS], exp_mask[NS];

   huffman_enc_gen #(.N_SYM(NS), .DATA_W(DW), .CNT_W(CW), .CODE_W(HW)) dut (
      .clk(clk), .reset(reset), .gray_valid(gray_valid), .gray_data(gray_data),
      .cnt_valid(cnt_valid), .cnt(cnt), .code_valid(code_valid), .hc(hc), .mask(mask));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: each node is a set of symbols; merging two sets prepends one code bit to every member.
   task automatic model(input int c[NS]);
      int w[NS], grp[NS], len[NS];
      bit act[NS];
      int a, b, lo, hi, nz;
      nz = 0;
      for (int i = 0; i < NS; i++) begin
         w[i] = c[i]; grp[i] = 1 << i; len[i] = 0; exp_hc[i] = 0; act[i] = 1'b1;
`ifdef HUFF_ZERO_SKIP_EN
         act[i] = (c[i] != 0);
`endif
         if (c[i] != 0) nz++;
      end
      for (int r = 0; r < NS - 1; r++) begin
         a = -1; b = -1;
         for (int i = 0; i < NS; i++)
            if (act[i] && (a < 0 || w[i] < w[a] || (w[i] == w[a] && i > a))) a = i;
         for (int i = 0; i < NS; i++)
            if (act[i] && i != a && (b < 0 || w[i] < w[b] || (w[i] == w[b] && i > b))) b = i;
         if (b < 0) continue;
         for (int k = 0; k < NS; k++) begin
            if (grp[a][k]) begin exp_hc[k] |= (1 << len[k]); len[k]++; end
            if (grp[b][k]) len[k]++;
         end
         lo = (a < b) ? a : b;
         hi = (a < b) ? b : a;
         w[lo] = w[a] + w[b];
         grp[lo] = grp[a] | grp[b];
         act[hi] = 1'b0;
      end
      for (int k = 0; k < NS; k++) exp_mask[k] = (1 << len[k]) - 1;
`ifdef HUFF_ZERO_SKIP_EN
      if (nz == 1) for (int k = 0; k < NS; k++) if (c[k] != 0) exp_mask[k] = 1;
`endif
   endtask

   // Sends c[k] copies of symbol k+1 plus n_junk out-of-range values, shuffled, as one contiguous burst.
   task automatic send_frame(input int c[NS], input int n_junk);
      int seq[$];
      int tmp, j;
      for (int k = 0; k < NS; k++) begin
         for (int r = 0; r < c[k]; r++) seq.push_back(k + 1);
         exp_cnt[k] = (c[k] > 255) ? 255 : c[k];
      end
      for (int r = 0; r < n_junk; r++) begin
         tmp = $urandom_range(0, 2);
         seq.push_back(tmp == 0 ? 0 : (tmp == 1 ? NS + 1 : 255));
      end
      for (int i = seq.size() - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = seq[i]; seq[i] = seq[j]; seq[j] = tmp;
      end
      foreach (seq[i]) begin
         gray_valid = 1'b1;
         gray_data  = DW'(seq[i]);
         step();
      end
      gray_valid = 1'b0;
      gray_data  = '0;
   endtask

   task automatic finish_frame(input string name);
      int lat;
      logic [NS*CW-1:0] ecnt;
      logic [NS*HW-1:0] ehc;
      for (int k = 0; k < NS; k++) begin
         ecnt[k*CW +: CW] = CW'(exp_cnt[k]);
         ehc[k*HW +: HW]  = HW'(exp_hc[k]);
      end
      step();
      chk({name, ".cnt_valid"}, 64'(cnt_valid), 64'(1));
      chk({name, ".cnt"}, 64'(cnt), 64'(ecnt));
      lat = 0;
      while (lat < 200) begin
         // Traffic during the build must be ignored.
         gray_valid = (lat < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
         gray_data  = DW'($urandom_range(1, NS));
         step();
         lat++;
         if (code_valid) break;
      end
      gray_valid = 1'b0;
      chk({name, ".latency"}, 64'(lat), 64'(LAT));
      chk({name, ".cnt_held"}, 64'(cnt), 64'(ecnt));
      for (int k = 0; k < NS; k++) begin
         chk($sformatf("%s.hc[%0d]", name, k + 1), 64'(hc[k*HW +: HW]), 64'(exp_hc[k]));
         chk($sformatf("%s.mask[%0d]", name, k + 1), 64'(mask[k*HW +: HW]), 64'(exp_mask[k]));
      end
      step();
      chk({name, ".code_valid_pulse"}, 64'(code_valid), 64'(0));
      chk({name, ".hc_held"}, 64'(hc), 64'(ehc));
      $display("frame %s: latency=%0d cnt=%h hc=%h mask=%h", name, lat, cnt, hc, mask);
   endtask

   task automatic chk_zero_outputs(input string name);
      chk({name, ".cnt_valid"}, 64'(cnt_valid), 64'(0));
      chk({name, ".code_valid"}, 64'(code_valid), 64'(0));
      chk({name, ".cnt"}, 64'(cnt), 64'(0));
      chk({name, ".hc"}, 64'(hc), 64'(0));
      chk({name, ".mask"}, 64'(mask), 64'(0));
   endtask

   initial begin
      int c[NS];
      int seen;
      reset = 1'b1;
      step(); step(); step();
      chk_zero_outputs("reset");
      reset = 1'b0;
      step();

      c = '{40, 6, 12, 8, 30, 4};
      send_frame(c, 0);
      exp_hc   = '{1, 0, 1, 1, 1, 1};
      exp_mask = '{1, 31, 7, 15, 3, 31};
      finish_frame("golden");

      c = '{10, 10, 10, 10, 10, 10};
      send_frame(c, 0);
      model(exp_cnt);
      finish_frame("tie");

      c = '{0, 0, 300, 0, 0, 0};
      send_frame(c, 0);
      model(exp_cnt);
      finish_frame("saturate");

      c = '{0, 5, 0, 0, 0, 0};
      send_frame(c, 9);
      model(exp_cnt);
      finish_frame("junk");

      c = '{0, 0, 0, 0, 0, 0};
      send_frame(c, 4);
      model(exp_cnt);
      finish_frame("allzero");

      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < NS; k++) c[k] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 25);
         send_frame(c, $urandom_range(1, 5));
         model(exp_cnt);
         finish_frame($sformatf("rand%0d", f));
      end

      // Abort a build in its third round; nothing may be published for that frame.
      c = '{40, 6, 12, 8, 30, 4};
      send_frame(c, 0);
      step();
      for (int i = 0; i < 30; i++) step();
      #2 reset = 1'b1;
      #1;
      chk_zero_outputs("midreset");
      step();
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (code_valid || cnt_valid) seen++;
      end
      chk("midreset.no_pulse", 64'(seen), 64'(0));
      $display("frame midreset: pulses after abort=%0d", seen);

      c = '{3, 17, 9, 1, 22, 5};
      send_frame(c, 2);
      model(exp_cnt);
      finish_frame("after_reset");

`ifdef HUFF_ZERO_SKIP_EN
      c = '{0, 5, 0, 0, 3, 0};
      send_frame(c, 0);
      exp_hc   = '{0, 0, 0, 0, 1, 0};
      exp_mask = '{0, 1, 0, 0, 1, 0};
      finish_frame("zeroskip");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
